// File: rtl/mac_dbg_pkg.sv
// Shared definitions for the MAC array debug readback path: ureg addresses,
// reader FSM states and the bit layout of the update-DR word.
package mac_dbg_pkg;

    localparam logic [1:0] UREG_WEIGHT = 2'b00;
    localparam logic [1:0] UREG_DATA   = 2'b01;
    localparam logic [1:0] UREG_ADD    = 2'b10;
    localparam logic [1:0] UREG_REMAIN = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        SETTLE = 2'd2,
        CAPT   = 2'd3
    } state_t;

    localparam int UPD_ADDR_LSB = 0;
    localparam int UPD_SEL_LSB  = 2;

    // The auto-increment flag is the MSB of the DR word, whatever its width.
    function automatic int upd_autoinc_bit(input int w);
        return w - 1;
    endfunction

endpackage

// File: rtl/dbg_shreg.sv
// W-bit DR register: parallel load (priority) or one-bit right shift, LSB on tdo.
// Single-cycle update; no backpressure, the caller guarantees legal strobes.
module dbg_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    input  logic         shift,
    input  logic         tdi,
    output logic [W-1:0] q,
    output logic         tdo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_dat;
        end else if (shift) begin
            q <= {tdi, q[W-1:1]};
        end
    end

    assign tdo = q[0];

endmodule

// File: rtl/mac_ureg_reader.sv
// Stalls the MAC array, muxes one unit's user register into the DR and shifts it out.
// Capture completes 4 cycles after the strobe once acked; strobes arriving while busy are dropped into ovr_o.
module mac_ureg_reader
    import mac_dbg_pkg::*;
#(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             update_i,
    input  logic             tdi_i,
    output logic             tdo_o,
    output logic             stall_req_o,
    input  logic             stall_ack_i,
    output logic [IDX_W-1:0] ureg_sel_o,
    output logic [1:0]       ureg_addr_o,
    input  logic [N*W-1:0]   ureg_data_i,
    output logic             busy_o,
    output logic             ovr_o
);

    localparam int FLAT_W      = IDX_W + 2;
    localparam int AUTOINC_BIT = upd_autoinc_bit(W);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q;
    logic [1:0]         addr_q;
    logic               autoinc_q;
    logic               ovr_q;
    logic [W-1:0]       mux_q, mux_d;
    logic [W-1:0]       shreg_q;
    logic               sh_shift, do_update, drop;
    logic               wrap;
    logic [FLAT_W-1:0]  flat_nxt;
    logic               unused_shreg;

    always_comb begin
        state_d   = state_q;
        sh_shift  = 1'b0;
        do_update = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_i) begin
                    state_d = STALL;
                    drop    = shift_i | update_i;
                end else if (shift_i) begin
                    sh_shift = 1'b1;
                    drop     = update_i;
                end else if (update_i) begin
                    do_update = 1'b1;
                end
            end
            STALL: begin
                drop = capture_i | shift_i | update_i;
                if (stall_ack_i) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                drop    = capture_i | shift_i | update_i;
                state_d = CAPT;
            end
            CAPT: begin
                drop    = capture_i | shift_i | update_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range selects (possible when N is not a power of two) read as zero.
    always_comb begin
        mux_d = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_q == IDX_W'(k)) begin
                mux_d = ureg_data_i[k*W +: W];
            end
        end
    end

    assign wrap     = (sel_q >= IDX_W'(N - 1)) && (addr_q == UREG_REMAIN);
    assign flat_nxt = {sel_q, addr_q} + FLAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= UREG_WEIGHT;
            autoinc_q <= 1'b0;
            ovr_q     <= 1'b0;
            mux_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SETTLE) begin
                mux_q <= mux_d;
            end
            if (do_update) begin
                addr_q    <= shreg_q[UPD_ADDR_LSB +: 2];
                sel_q     <= shreg_q[UPD_SEL_LSB +: IDX_W];
                autoinc_q <= shreg_q[AUTOINC_BIT];
            end else if (state_q == CAPT && autoinc_q) begin
                if (wrap) begin
                    sel_q  <= '0;
                    addr_q <= UREG_WEIGHT;
                end else begin
                    {sel_q, addr_q} <= flat_nxt;
                end
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

    dbg_shreg #(.W(W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == CAPT),
        .load_dat (mux_q),
        .shift    (sh_shift),
        .tdi      (tdi_i),
        .q        (shreg_q),
        .tdo      (tdo_o)
    );

    assign unused_shreg = ^shreg_q;
    assign stall_req_o  = (state_q != IDLE);
    assign busy_o       = (state_q != IDLE);
    assign ovr_o        = ovr_q;
    assign ureg_sel_o   = sel_q;
    assign ureg_addr_o  = addr_q;

endmodule

// File: tb/tb_mac_ureg_reader.sv
// Directed bench for mac_ureg_reader: an N=4 and an N=3 instance run in lockstep.
module tb_mac_ureg_reader;

    logic        clk = 1'b0;
    logic        rst, capture, shift, update, tdi, stall_ack;
    logic        tdo4, stall4, busy4, ovr4;
    logic        tdo3, stall3, busy3, ovr3;
    logic [1:0]  sel4, addr4, sel3, addr3;
    logic [31:0] ureg4;
    logic [23:0] ureg3;
    logic [7:0]  d4, d3;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cnt;

    always #5 clk = ~clk;

    mac_ureg_reader #(.W(8), .N(4)) dut4 (
        .clk(clk), .rst(rst), .capture_i(capture), .shift_i(shift), .update_i(update),
        .tdi_i(tdi), .tdo_o(tdo4), .stall_req_o(stall4), .stall_ack_i(stall_ack),
        .ureg_sel_o(sel4), .ureg_addr_o(addr4), .ureg_data_i(ureg4),
        .busy_o(busy4), .ovr_o(ovr4)
    );

    mac_ureg_reader #(.W(8), .N(3)) dut3 (
        .clk(clk), .rst(rst), .capture_i(capture), .shift_i(shift), .update_i(update),
        .tdi_i(tdi), .tdo_o(tdo3), .stall_req_o(stall3), .stall_ack_i(stall_ack),
        .ureg_sel_o(sel3), .ureg_addr_o(addr3), .ureg_data_i(ureg3),
        .busy_o(busy3), .ovr_o(ovr3)
    );

    // Array model: unit0 weight = A5, unit3 add = 7F, else {01, unit, 00, addr}.
    function automatic logic [7:0] ureg_val(input int k, input logic [1:0] a);
        if (k == 0 && a == 2'd0) return 8'hA5;
        if (k == 3 && a == 2'd2) return 8'h7F;
        return {2'b01, 2'(k), 2'b00, a};
    endfunction

    always_comb begin
        ureg4 = '0;
        ureg3 = '0;
        for (int k = 0; k < 4; k++) ureg4[k*8 +: 8] = ureg_val(k, addr4);
        for (int k = 0; k < 3; k++) ureg3[k*8 +: 8] = ureg_val(k, addr3);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [7:0] din, output logic [7:0] o4, output logic [7:0] o3);
        for (int i = 0; i < 8; i++) begin
            o4[i] = tdo4;
            o3[i] = tdo3;
            tdi   = din[i];
            shift = 1'b1;
            tick();
            shift = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy4 && !busy3) break;
            tick();
        end
        chk("idle_timeout", {busy4, busy3}, 2'b00);
    endtask

    task automatic strobe(input logic c, input logic s, input logic u);
        capture = c;
        shift   = s;
        update  = u;
        tick();
        capture = 1'b0;
        shift   = 1'b0;
        update  = 1'b0;
    endtask

    task automatic capture_read(output logic [7:0] o4, output logic [7:0] o3);
        strobe(1'b1, 1'b0, 1'b0);
        wait_idle();
        shift_word(8'h00, o4, o3);
    endtask

    initial begin
        rst = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0; stall_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_tdo", tdo4, 0);
        chk("rst_stall", stall4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_ovr", ovr4, 0);
        chk("rst_sel_addr", {sel4, addr4}, 0);

        // Basic capture, ack already high: busy through CAPT, clear at t+4.
        stall_ack = 1'b1;
        strobe(1'b1, 1'b0, 1'b0);
        chk("t1_busy_stall", {busy4, stall4}, 2'b11);
        tick();
        tick();
        chk("t3_busy", busy4, 1);
        tick();
        chk("t4_busy_stall", {busy4, stall4}, 2'b00);
        shift_word(8'h0E, d4, d3);
        chk("u0_weight_bits", d4, 8'hA5);
        chk("u0_weight_n3", d3, 8'hA5);

        // Update 0x0E -> sel=3 addr=2, delayed ack.
        strobe(1'b0, 1'b0, 1'b1);
        chk("upd_sel", sel4, 3);
        chk("upd_addr", addr4, 2);
        stall_ack = 1'b0;
        strobe(1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (!stall4) break;
            cnt++;
            if (cnt == 5) stall_ack = 1'b1;
            tick();
        end
        chk("stall_len", cnt, 7);
        shift_word(8'h8D, d4, d3);
        chk("u3_add", d4, 8'h7F);
        chk("n3_sel3_zero", d3, 8'h00);

        // Update 0x8D: autoinc, sel=3, addr=1; four captures walk and wrap.
        strobe(1'b0, 1'b0, 1'b1);
        chk("ai_sel_addr", {sel4, addr4}, 4'b1101);
        capture_read(d4, d3);
        chk("ai0_u3_data", d4, 8'h71);
        chk("ai0_n3", d3, 8'h00);
        capture_read(d4, d3);
        chk("ai1_u3_add", d4, 8'h7F);
        capture_read(d4, d3);
        chk("ai2_u3_remain", d4, 8'h73);
        chk("ai2_n3", d3, 8'h00);
        capture_read(d4, d3);
        chk("ai3_u0_weight", d4, 8'hA5);
        chk("ai3_n3_wrap", d3, 8'hA5);
        chk("ai_after", {sel4, addr4}, 4'b0001);

        // Autoinc from (2,3): N=3 wraps to (0,0), N=4 goes to (3,0).
        shift_word(8'h8B, d4, d3);
        strobe(1'b0, 1'b0, 1'b1);
        chk("n3_sel_addr", {sel3, addr3}, 4'b1011);
        capture_read(d4, d3);
        chk("u2_remain", d4, 8'h63);
        chk("u2_remain_n3", d3, 8'h63);
        capture_read(d4, d3);
        chk("u3_weight", d4, 8'h70);
        chk("n3_wrap_weight", d3, 8'hA5);
        chk("ovr_clean", {ovr4, ovr3}, 2'b00);

        // Simultaneous capture+update, then shift while stalled.
        shift_word(8'h00, d4, d3);
        strobe(1'b0, 1'b0, 1'b1);
        shift_word(8'h01, d4, d3);
        stall_ack = 1'b0;
        strobe(1'b1, 1'b0, 1'b1);
        chk("cu_busy", busy4, 1);
        chk("cu_ovr", {ovr4, ovr3}, 2'b11);
        chk("cu_addr_kept", addr4, 0);
        tdi = 1'b0;
        strobe(1'b0, 1'b1, 1'b0);
        chk("stall_shift_dropped", tdo4, 1);
        stall_ack = 1'b1;
        wait_idle();
        shift_word(8'h00, d4, d3);
        chk("cu_capture", d4, 8'hA5);
        chk("ovr_sticky", ovr4, 1);

        // Reset during SETTLE.
        strobe(1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_stall_busy", {stall4, busy4}, 2'b00);
        chk("rst_mid_ovr", ovr4, 0);
        chk("rst_mid_tdo", tdo4, 0);
        shift_word(8'h00, d4, d3);
        chk("rst_mid_shreg", d4, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
